// File: rtl/accel_pkg.sv
// Shared parameters for the accelerator stream FIFOs.
// Default word width and FIFO geometry.
package accel_pkg;

  localparam int ACC_WIDTH     = 32;
  localparam int FIFO_ADDR_W   = 4;
  localparam int FIFO_AF_LEVEL = 12;

endpackage

// File: rtl/fifo_ram.sv
// Register-array storage for the stream FIFO.
// Ports: one write port (we_i/waddr_i/wdata_i), one registered read port (re_i/raddr_i/rdata_o).
module fifo_ram
  import accel_pkg::*;
#(
  parameter int WIDTH  = ACC_WIDTH,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  localparam int DEPTH = 2**ADDR_W;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Same-address read/write returns the old word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/accel_stream_fifo.sv
// Word FIFO between top level and one accelerator, with status and sticky errors.
// Ports: put_req/data_in write, get_req/data_out/data_valid read, full/empty/almost_full/count, overflow/underflow/clr_err.
module accel_stream_fifo
  import accel_pkg::*;
#(
  parameter int WIDTH    = ACC_WIDTH,
  parameter int ADDR_W   = FIFO_ADDR_W,
  parameter int AF_LEVEL = FIFO_AF_LEVEL
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              put_req,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              get_req,
  output logic [WIDTH-1:0]  data_out,
  output logic              data_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AF_C    = AF_LEVEL[ADDR_W:0];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              dv_q;
  logic              wr_ok, rd_ok;

  assign full        = (cnt_q == DEPTH_C);
  assign empty       = (cnt_q == '0);
  assign almost_full = (cnt_q >= AF_C);

  // A put at full rides on a same-cycle pop; a get at empty never
  // falls through to the word being written.
  assign wr_ok = put_req && (!full || get_req);
  assign rd_ok = get_req && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({wr_ok, rd_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    // New error events beat a coincident clear.
    ovf_d = (put_req && !wr_ok) || (ovf_q && !clr_err);
    unf_d = (get_req && !rd_ok) || (unf_q && !clr_err);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dv_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      dv_q     <= rd_ok;
    end
  end

  fifo_ram #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we_i    (wr_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .re_i    (rd_ok),
    .raddr_i (rd_ptr_q),
    .rdata_o (data_out)
  );

  assign data_valid = dv_q;
  assign count      = cnt_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;

endmodule
